// File: rtl/rv64i_pkg.sv
// rv64i_pkg: constants and types shared by the RV64I front-end blocks.
package rv64i_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4,
    TRAPPED = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for the RV64I core.
// Owns the PC, runs a single-outstanding req/gnt/rvalid handshake to
// instruction memory, presents each instruction with its PC+4 to the fetch
// pipeline register, and applies execute-stage redirects, dropping any
// response that belongs to a superseded request.
// Build option: FETCH_CTRL_MISALIGN_TRAP_EN adds the fetch_misalign output and
// parks the fetcher in TRAPPED on a misaligned redirect target.
module fetch_ctrl #(
  parameter int              XLEN     = rv64i_pkg::XLEN,
  parameter int              ILEN     = rv64i_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            decode_stall,
  output logic [ILEN-1:0] fetch_inst,
  output logic [XLEN-1:0] fetch_pc_next,
  output logic            fetch_stall,
  output logic            fetch_invalid
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign
`endif
);
  import rv64i_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic            req_reg, req_next;
  logic [ILEN-1:0] inst_reg, inst_next;
  logic [XLEN-1:0] pcn_reg, pcn_next;
  logic            invalid_reg, invalid_next;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_tgt;
  logic            in_flight;

  // Wraps modulo 2^XLEN by construction.
  assign pc_plus4     = pc_reg + XLEN'(4);
  // Low two bits of a redirect target are always dropped from the fetch address.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // A response is still owed by memory after this cycle: it was granted now,
  // or we are waiting/discarding and it has not arrived yet.
  assign in_flight = ((state_reg == REQ) && imem_gnt) ||
                     (((state_reg == WAIT) || (state_reg == DISCARD)) && !imem_rvalid);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  logic misalign_reg, misalign_next;
  logic redirect_bad;

  assign redirect_bad   = |redirect_pc[1:0];
  assign fetch_misalign = misalign_reg;
`endif

  // Next-state and next-output logic; redirect overrides everything else.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    pcn_next     = pcn_reg;
    invalid_next = invalid_reg;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    misalign_next = misalign_reg;
`endif

    // A presented instruction is consumed when decode is not stalling.
    if (!invalid_reg && !decode_stall) begin
      invalid_next = 1'b1;
    end

    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          inst_next    = imem_rdata;
          pcn_next     = pc_plus4;
          pc_next      = pc_plus4;
          invalid_next = 1'b0;
          state_next   = decode_stall ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (!decode_stall) begin
          state_next = REQ;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
          state_next = misalign_reg ? TRAPPED : REQ;
`else
          state_next = REQ;
`endif
        end
      end
      TRAPPED: state_next = TRAPPED;
      default: state_next = IDLE;
    endcase

    if (redirect_valid) begin
      pc_next      = redirect_tgt;
      invalid_next = 1'b1;
      // Any response landing this cycle belongs to the old path.
      inst_next    = inst_reg;
      pcn_next     = pcn_reg;
      state_next   = in_flight ? DISCARD : REQ;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      misalign_next = redirect_bad;
      if (redirect_bad && !in_flight) begin
        state_next = TRAPPED;
      end
`endif
    end

    // Request outputs are registered so they reflect the state being entered.
    req_next  = (state_next == REQ);
    addr_next = req_next ? pc_next : addr_reg;
  end

  // State, PC and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      addr_reg    <= RESET_PC;
      req_reg     <= 1'b0;
      inst_reg    <= ILEN'(NOP_INST);
      pcn_reg     <= RESET_PC;
      invalid_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      addr_reg    <= addr_next;
      req_reg     <= req_next;
      inst_reg    <= inst_next;
      pcn_reg     <= pcn_next;
      invalid_reg <= invalid_next;
    end
  end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  // Misalignment flag follows the most recent redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end
`endif

  assign imem_req      = req_reg;
  assign imem_addr     = addr_reg;
  assign fetch_inst    = inst_reg;
  assign fetch_pc_next = pcn_reg;
  assign fetch_invalid = invalid_reg;
  assign fetch_stall   = decode_stall;

endmodule
